// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, widths and the colour payload type.
package vga_pkg;

  // Pixel clock divider: clk cycles per pixel.
  localparam int unsigned CLK_DIV  = 2;

  // Horizontal timing, in pixels.
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing, in lines.
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Port and counter widths.
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned ADDR_W   = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam rgb24_t FG_COLOR = 24'hFFFFFF;
  localparam rgb24_t BG_COLOR = 24'h000000;

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel divider plus horizontal/vertical scan counters with sync and active decode.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   pix_en_o           registered 1-clk pulse in the last clk of each pixel period
//   frame_start_o      registered pulse coinciding with pix_en_o at h=0, v=0
//   vga_clk_o          registered pixel clock, high in the second half of the period
//   h_nxt_c_o/v_nxt_c_o  counter values after the coming edge
//   active_c_o         current (pre-advance) position is in the visible area
//   nxt_active_c_o     post-advance position is in the visible area
//   hsync_c_o/vsync_c_o  current position lies inside the sync pulse
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int unsigned P_CLK_DIV  = CLK_DIV,
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_FP     = H_FP,
  parameter int unsigned P_H_SYNC   = H_SYNC,
  parameter int unsigned P_H_BP     = H_BP,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_FP     = V_FP,
  parameter int unsigned P_V_SYNC   = V_SYNC,
  parameter int unsigned P_V_BP     = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             pix_en_o,
  output logic             frame_start_o,
  output logic             vga_clk_o,
  output logic [CNT_W-1:0] h_nxt_c_o,
  output logic [CNT_W-1:0] v_nxt_c_o,
  output logic             active_c_o,
  output logic             nxt_active_c_o,
  output logic             hsync_c_o,
  output logic             vsync_c_o
);

  localparam int unsigned HT    = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int unsigned VT    = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int unsigned DIV_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             pix_en_q, pix_en_d;
  logic             frame_start_q, frame_start_d;
  logic             vga_clk_q, vga_clk_d;

  // Next-state: divider always runs, counters advance on the registered pix_en.
  always_comb begin
    div_d         = (div_q == DIV_W'(P_CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    h_d           = h_q;
    v_d           = v_q;
    if (pix_en_q) begin
      if (h_q == CNT_W'(HT - 1)) begin
        h_d = '0;
        v_d = (v_q == CNT_W'(VT - 1)) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
    // pix_en/vga_clk are registered copies of what div_d decodes to.
    pix_en_d      = (div_d == DIV_W'(P_CLK_DIV - 1));
    vga_clk_d     = (div_d >= DIV_W'(P_CLK_DIV / 2));
    frame_start_d = pix_en_d && (h_d == '0) && (v_d == '0);
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
    end
  end

  assign pix_en_o       = pix_en_q;
  assign frame_start_o  = frame_start_q;
  assign vga_clk_o      = vga_clk_q;
  assign h_nxt_c_o      = h_d;
  assign v_nxt_c_o      = v_d;
  assign active_c_o     = (h_q < CNT_W'(P_H_ACTIVE)) && (v_q < CNT_W'(P_V_ACTIVE));
  assign nxt_active_c_o = (h_d < CNT_W'(P_H_ACTIVE)) && (v_d < CNT_W'(P_V_ACTIVE));
  assign hsync_c_o      = (h_q >= CNT_W'(P_H_ACTIVE + P_H_FP)) &&
                          (h_q <  CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC));
  assign vsync_c_o      = (v_q >= CNT_W'(P_V_ACTIVE + P_V_FP)) &&
                          (v_q <  CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC));

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan controller: drives x/y/ADDR to object testers and produces registered RGB, sync and
// blank one pixel period behind the coordinates.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   isInSquare         hit flag for the currently presented x/y/ADDR
//   x, y, ADDR         scan column, row and linear address (y*H_ACTIVE+x), held in blanking
//   pix_en             1-clk pulse per pixel period; frame_start marks pixel (0,0)
//   vga_clk            pixel clock for the DAC
//   hsync_n, vsync_n   active-low syncs; blank_n high in active video
//   r, g, b            colour channels
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned P_CLK_DIV  = CLK_DIV,
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_FP     = H_FP,
  parameter int unsigned P_H_SYNC   = H_SYNC,
  parameter int unsigned P_H_BP     = H_BP,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_FP     = V_FP,
  parameter int unsigned P_V_SYNC   = V_SYNC,
  parameter int unsigned P_V_BP     = V_BP,
  parameter rgb24_t      P_FG_COLOR = FG_COLOR,
  parameter rgb24_t      P_BG_COLOR = BG_COLOR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              isInSquare,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] ADDR,
  output logic              pix_en,
  output logic              frame_start,
  output logic              vga_clk,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              blank_n,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);

  logic             pix_en_c;
  logic [CNT_W-1:0] h_nxt_c, v_nxt_c;
  logic             active_c, nxt_active_c, hsync_c, vsync_c;

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              blank_q, blank_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  rgb24_t            rgb_q, rgb_d;

  vga_timing_counter #(
    .P_CLK_DIV  (P_CLK_DIV),
    .P_H_ACTIVE (P_H_ACTIVE),
    .P_H_FP     (P_H_FP),
    .P_H_SYNC   (P_H_SYNC),
    .P_H_BP     (P_H_BP),
    .P_V_ACTIVE (P_V_ACTIVE),
    .P_V_FP     (P_V_FP),
    .P_V_SYNC   (P_V_SYNC),
    .P_V_BP     (P_V_BP)
  ) u_timing (
    .clk_i          (clk),
    .rst_ni         (resetn),
    .pix_en_o       (pix_en_c),
    .frame_start_o  (frame_start),
    .vga_clk_o      (vga_clk),
    .h_nxt_c_o      (h_nxt_c),
    .v_nxt_c_o      (v_nxt_c),
    .active_c_o     (active_c),
    .nxt_active_c_o (nxt_active_c),
    .hsync_c_o      (hsync_c),
    .vsync_c_o      (vsync_c)
  );

  // Coordinates track the counters into each active pixel; the output stage uses the
  // pre-advance position so it lands one pixel behind x/y/ADDR.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    blank_d = blank_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en_c) begin
      if (nxt_active_c) begin
        x_d = X_W'(h_nxt_c);
        y_d = Y_W'(v_nxt_c);
        // Incremental address: only the frame origin breaks the +1 sequence.
        addr_d = ((h_nxt_c == '0) && (v_nxt_c == '0)) ? '0 : addr_q + ADDR_W'(1);
      end
      blank_d = active_c;
      hsync_d = !hsync_c;
      vsync_d = !vsync_c;
      rgb_d   = active_c ? (isInSquare ? P_FG_COLOR : P_BG_COLOR) : '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      blank_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      blank_q <= blank_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pix_en  = pix_en_c;
  assign x       = x_q;
  assign y       = y_q;
  assign ADDR    = addr_q;
  assign blank_n = blank_q;
  assign hsync_n = hsync_q;
  assign vsync_n = vsync_q;
  assign r       = rgb_q.r;
  assign g       = rgb_q.g;
  assign b       = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench: a shrunk-timing instance checked over several frames (incl. mid-frame reset) and a
// default-timing instance checked over its first lines, both against a pixel-index model.
module tb_vga_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pix_en;
    logic        frame_start;
    logic        vga_clk;
    logic        hsync_n;
    logic        vsync_n;
    logic        blank_n;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [18:0] addr;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    int ha, hfp, hs, hb, va, vfp, vs, vb, div, tx, ty;
  } tim_t;

  // Small instance signals
  logic        rst_s, hit_s;
  logic [9:0]  x_s;
  logic [8:0]  y_s;
  logic [18:0] addr_s;
  logic        pe_s, fs_s, vc_s, hs_s, vs_s, bl_s;
  logic [7:0]  r_s, g_s, b_s;
  // Default instance signals
  logic        rst_d, hit_d;
  logic [9:0]  x_d;
  logic [8:0]  y_d;
  logic [18:0] addr_d;
  logic        pe_d, fs_d, vc_d, hs_d, vs_d, bl_d;
  logic [7:0]  r_d, g_d, b_d;

  vga_scan_controller #(
    .P_CLK_DIV(2), .P_H_ACTIVE(16), .P_H_FP(3), .P_H_SYNC(4), .P_H_BP(5),
    .P_V_ACTIVE(6), .P_V_FP(2), .P_V_SYNC(2), .P_V_BP(2)
  ) dut_s (
    .clk(clk), .resetn(rst_s), .isInSquare(hit_s), .x(x_s), .y(y_s), .ADDR(addr_s),
    .pix_en(pe_s), .frame_start(fs_s), .vga_clk(vc_s), .hsync_n(hs_s), .vsync_n(vs_s),
    .blank_n(bl_s), .r(r_s), .g(g_s), .b(b_s)
  );

  vga_scan_controller dut_d (
    .clk(clk), .resetn(rst_d), .isInSquare(hit_d), .x(x_d), .y(y_d), .ADDR(addr_d),
    .pix_en(pe_d), .frame_start(fs_d), .vga_clk(vc_d), .hsync_n(hs_d), .vsync_n(vs_d),
    .blank_n(bl_d), .r(r_d), .g(g_d), .b(b_d)
  );

  int n_chk  = 0;
  int n_pass = 0;

  tim_t tim_s, tim_d;
  int   c_s = 0, c_d = 0;
  logic hp_s = 1'b0, hp_d = 1'b0;
  int   hold = 0;
  bit   did_rst = 1'b0;

  localparam int FT_S   = 28 * 12;
  localparam int RST_AT = 2 * (2 * FT_S + 3 * 28 + 7);

  // Expected outputs after c clk edges since reset release, from pixel index arithmetic.
  function automatic exp_t model(input tim_t t, input int c, input logic hit_prev);
    exp_t e;
    int ht, vt, ft, n, d, p, h, v, q, qh, qv, xx, yy;
    bit act;
    ht = t.ha + t.hfp + t.hs + t.hb;
    vt = t.va + t.vfp + t.vs + t.vb;
    ft = ht * vt;
    n  = c / t.div;
    d  = c % t.div;
    p  = n % ft;
    h  = p % ht;
    v  = p / ht;
    e.pix_en      = (d == t.div - 1);
    e.vga_clk     = (d >= t.div / 2);
    e.frame_start = e.pix_en && (p == 0);
    if (v < t.va) begin
      yy = v;
      xx = (h < t.ha) ? h : t.ha - 1;
    end else begin
      yy = t.va - 1;
      xx = t.ha - 1;
    end
    e.x    = 10'(xx);
    e.y    = 9'(yy);
    e.addr = 19'(yy * t.ha + xx);
    if (n == 0) begin
      e.blank_n = 1'b0;
      e.hsync_n = 1'b1;
      e.vsync_n = 1'b1;
      e.rgb     = 24'h0;
    end else begin
      q  = (n - 1) % ft;
      qh = q % ht;
      qv = q / ht;
      act = (qh < t.ha) && (qv < t.va);
      e.blank_n = act;
      e.hsync_n = !((qh >= t.ha + t.hfp) && (qh < t.ha + t.hfp + t.hs));
      e.vsync_n = !((qv >= t.va + t.vfp) && (qv < t.va + t.vfp + t.vs));
      e.rgb     = (act && hit_prev) ? 24'hFFFFFF : 24'h000000;
    end
    return e;
  endfunction

  // Object-block stand-in: hit only at the target pixel when active, random noise in blanking.
  function automatic logic hit_for(input tim_t t, input int c);
    int ht, vt, p, h, v;
    ht = t.ha + t.hfp + t.hs + t.hb;
    vt = t.va + t.vfp + t.vs + t.vb;
    p  = (c / t.div) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    if (h < t.ha && v < t.va) return (h == t.tx) && (v == t.ty);
    return 1'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic cmp_all(input string tag, input exp_t e, input exp_t a);
    chk({tag, ".pix_en"},      32'(a.pix_en),      32'(e.pix_en));
    chk({tag, ".frame_start"}, 32'(a.frame_start), 32'(e.frame_start));
    chk({tag, ".vga_clk"},     32'(a.vga_clk),     32'(e.vga_clk));
    chk({tag, ".hsync_n"},     32'(a.hsync_n),     32'(e.hsync_n));
    chk({tag, ".vsync_n"},     32'(a.vsync_n),     32'(e.vsync_n));
    chk({tag, ".blank_n"},     32'(a.blank_n),     32'(e.blank_n));
    chk({tag, ".x"},           32'(a.x),           32'(e.x));
    chk({tag, ".y"},           32'(a.y),           32'(e.y));
    chk({tag, ".addr"},        32'(a.addr),        32'(e.addr));
    chk({tag, ".rgb"},         32'(a.rgb),         32'(e.rgb));
  endtask

  task automatic step(input int i);
    exp_t a;
    logic v;
    @(negedge clk);
    // Model comparison; during reset the model at c=0 gives the reset values.
    a = '{pe_s, fs_s, vc_s, hs_s, vs_s, bl_s, x_s, y_s, addr_s, {r_s, g_s, b_s}};
    cmp_all($sformatf("small@%0d", c_s), model(tim_s, rst_s ? c_s : 0, hp_s), a);
    a = '{pe_d, fs_d, vc_d, hs_d, vs_d, bl_d, x_d, y_d, addr_d, {r_d, g_d, b_d}};
    cmp_all($sformatf("dflt@%0d", c_d), model(tim_d, rst_d ? c_d : 0, hp_d), a);

    // Hand-computed anchors.
    if (rst_d) begin
      if (c_d == 1)        chk("dflt.first_frame_start", 32'(fs_d), 32'd1);
      if (c_d == 2 * 639)  chk("dflt.addr_639_0",  32'(addr_d), 32'd639);
      if (c_d == 2 * 800)  chk("dflt.addr_0_1",    32'(addr_d), 32'd640);
      if (c_d == 2 * 800)  chk("dflt.xy_0_1",      {x_d, 13'd0, y_d}, {10'd0, 13'd0, 9'd1});
      if (c_d == 2 * 640)  chk("dflt.blank_last_active", 32'(bl_d), 32'd1);
      if (c_d == 2 * 641)  chk("dflt.blank_first_fp",    32'(bl_d), 32'd0);
      if (c_d == 2 * 656)  chk("dflt.hsync_before",  32'(hs_d), 32'd1);
      if (c_d == 2 * 657)  chk("dflt.hsync_start",   32'(hs_d), 32'd0);
      if (c_d == 2 * 752)  chk("dflt.hsync_last",    32'(hs_d), 32'd0);
      if (c_d == 2 * 753)  chk("dflt.hsync_end",     32'(hs_d), 32'd1);
      if (c_d == 2 * 1120) chk("dflt.rgb_before_hit", {8'd0, r_d, g_d, b_d}, 32'h000000);
      if (c_d == 2 * 1121) chk("dflt.rgb_hit",        {8'd0, r_d, g_d, b_d}, 32'hFFFFFF);
      if (c_d == 2 * 1122) chk("dflt.rgb_after_hit",  {8'd0, r_d, g_d, b_d}, 32'h000000);
    end
    if (rst_s) begin
      if (c_s == 310)          chk("small.addr_max",     32'(addr_s), 32'd95);
      if (c_s == 244)          chk("small.rgb_hit",      {8'd0, r_s, g_s, b_s}, 32'hFFFFFF);
      if (c_s == 2 * 224)      chk("small.vsync_before", 32'(vs_s), 32'd1);
      if (c_s == 2 * 225)      chk("small.vsync_start",  32'(vs_s), 32'd0);
      if (c_s == 2 * FT_S)     chk("small.addr_wrap",    32'(addr_s), 32'd0);
      if (c_s == 2 * FT_S + 1) chk("small.frame_start",  32'(fs_s), 32'd1);
      if (c_s == RST_AT)       chk("small.addr_pre_reset", 32'(addr_s), 32'd55);
    end

    // Input drive: random early in the period, final value just before the sampling edge.
    if (rst_s && (c_s % tim_s.div == tim_s.div - 1)) begin
      v = hit_for(tim_s, c_s); hit_s = v; hp_s = v;
    end else hit_s = 1'($urandom);
    if (rst_d && (c_d % tim_d.div == tim_d.div - 1)) begin
      v = hit_for(tim_d, c_d); hit_d = v; hp_d = v;
    end else hit_d = 1'($urandom);

    // Reset sequencing: initial release, then one mid-frame reset of the small instance.
    if (i == 0) begin
      rst_s = 1'b1;
      rst_d = 1'b1;
    end else if (rst_s && !did_rst && c_s == RST_AT) begin
      rst_s = 1'b0; c_s = 0; hold = 3; did_rst = 1'b1;
    end else if (!rst_s) begin
      hold--;
      if (hold == 0) rst_s = 1'b1;
    end

    @(posedge clk);
    if (rst_s) c_s++;
    if (rst_d) c_d++;
  endtask

  initial begin
    tim_s = '{16, 3, 4, 5, 6, 2, 2, 2, 2, 9, 4};
    tim_d = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 320, 1};
    rst_s = 1'b0;
    rst_d = 1'b0;
    hit_s = 1'b0;
    hit_d = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5000; i++) step(i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
